// File: rtl/mul_cs_iter_if.sv
// Operand/product handshake bundle for the iterative carry-save multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface mul_cs_iter_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid,
        output op1,
        output op2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  op1,
        input  op2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );
endinterface

// File: rtl/mul_cs_iter.sv
// Iterative unsigned multiplier: one partial product per cycle folded into a
// carry-save accumulator, then a single carry-propagate add resolves the result.
module mul_cs_iter #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mul_cs_iter_if.slave   bus
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    sum_r;
    logic [PW-1:0]    carry_r;
    logic [PW-1:0]    product_r;
    logic [CW-1:0]    cnt;

    logic [PW-1:0]    pp;
    logic [PW-1:0]    maj;
    logic [PW-1:0]    sum_nxt;
    logic [PW-1:0]    carry_nxt;

    logic             accept;
    logic             consume;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign consume = (state == DONE) && bus.out_ready;

    // 3:2 compressor: the carry vector's dropped MSB is always zero because
    // the running total never exceeds the final 2*WIDTH-bit product.
    always_comb begin
        pp        = '0;
        if (mplier_r[cnt[IW-1:0]])
            pp = {{WIDTH{1'b0}}, mcand_r} << cnt;
        maj       = (sum_r & carry_r) | (sum_r & pp) | (carry_r & pp);
        sum_nxt   = sum_r ^ carry_r ^ pp;
        carry_nxt = maj << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == LAST) state_nxt = RESOLVE;
            RESOLVE: state_nxt = DONE;
            DONE:    if (consume) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; product_r is only rewritten on RESOLVE so it stays
    // stable through DONE and the following idle period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r   <= '0;
            mplier_r  <= '0;
            sum_r     <= '0;
            carry_r   <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand_r  <= bus.op1;
                        mplier_r <= bus.op2;
                        sum_r    <= '0;
                        carry_r  <= '0;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    sum_r   <= sum_nxt;
                    carry_r <= carry_nxt;
                    cnt     <= cnt + 1'b1;
                end
                RESOLVE: begin
                    product_r <= sum_r + carry_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == BUSY) || (state == RESOLVE);
    assign bus.product   = product_r;

endmodule

// File: tb/tb_mul_cs_iter.sv
// Directed and randomised checks of mul_cs_iter against a 64-bit reference multiply.
module tb_mul_cs_iter;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   mul_cs_iter_if #(.WIDTH(WIDTH)) bus();

   mul_cs_iter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present operands and hold in_valid until the accepting edge has passed.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      bus.op1      = a;
      bus.op2      = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100)
         checkOutput("accept_timeout", 64'(n), 64'(0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op1      = ~a;
      bus.op2      = $urandom;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int throttle);
      int lat;
      logic [63:0] inv;
      applyStimulus(a, b);
      waitResult(lat);
      checkOutput({tag, "_lat"}, 64'(lat), 64'(33));
      checkOutput({tag, "_prod"}, bus.product, exp);
      inv = dut.sum_r + dut.carry_r;
      checkOutput({tag, "_inv"}, inv, exp);
      repeat (throttle) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_idle"}, 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
   endtask

   initial begin
      logic [63:0] hold;
      logic [31:0] a;
      logic [31:0] b;
      int lat;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op1       = '0;
      bus.op2       = '0;

      // Reset asserted between edges must take effect without a clock.
      #3 rst = 1'b1;
      #1;
      checkOutput("rst_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
      checkOutput("rst_prod", bus.product, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      runOp("basic",   32'd3,        32'd5,        64'h0F,                  0);
      runOp("max",     32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001,  1);
      runOp("msb",     32'h80000000, 32'd2,        64'h1_00000000,         0);
      runOp("zero",    32'd0,        32'hFFFFFFFF, 64'h0,                  0);
      runOp("mixed",   32'h00012345, 32'h00000100, 64'h0000_0000_0123_4500, 2);

      // Backpressure: product held, nothing accepted while out_ready is low.
      applyStimulus(32'h1234, 32'h5678);
      waitResult(lat);
      checkOutput("bp_lat", 64'(lat), 64'(33));
      checkOutput("bp_first", bus.product, 64'h0626_0060);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.op1      = $urandom;
         bus.op2      = $urandom;
         @(posedge clk); #1;
         checkOutput("bp_prod", bus.product, 64'h0626_0060);
         checkOutput("bp_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b010));
      end
      // in_valid and out_ready together in DONE only consume the product.
      bus.op1       = 32'd5;
      bus.op2       = 32'd6;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("bp_release", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checkOutput("bp_accept_next", 64'({bus.in_ready, bus.busy}), 64'(2'b01));
      waitResult(lat);
      checkOutput("bp_next_lat", 64'(lat), 64'(33));
      checkOutput("bp_next_prod", bus.product, 64'd30);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // Abort mid-operation, then confirm a clean following operation.
      applyStimulus(32'd100, 32'd200);
      repeat (10) begin
         @(posedge clk); #1;
      end
      checkOutput("abort_busy", 64'(bus.busy), 64'(1));
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
      checkOutput("abort_prod", bus.product, 64'h0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      runOp("abort_next", 32'd7, 32'd9, 64'd63, 0);

      // Back-to-back operations with throttled consumer.
      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 7))
            0:       a = 32'd0;
            1:       a = 32'd1;
            2:       a = 32'hFFFFFFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'd1;
            2:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         hold = 64'(a) * 64'(b);
         runOp("rand", a, b, hold, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
